// File: rtl/vec_ldst_unit.sv
// Vector load/store sequencer: vld streams 16 memory words into one vector
// register, vst streams one vector register out to 16 consecutive addresses.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start
// LD_RD   | issuing RD for lanes 0..15, capturing the previous lane's word
// LD_WAIT | last read returns, lane 15 captured
// LD_VWR  | single parallel write of the assembled vector
// ST_VRD  | parallel read of the source vector register
// ST_WR   | issuing WR for lanes 0..15
// FIN     | done pulse; behaves like IDLE so a new start is taken here
module vec_ldst_unit #(
    parameter int LANES = 16
) (
    input  logic                  Clk1,
    input  logic                  Reset,
    input  logic                  start,
    input  logic                  op,
    input  logic [2:0]            vreg,
    input  logic [15:0]           base,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           Addr,
    output logic                  RD,
    output logic                  WR,
    output logic [15:0]           DataOut,
    input  logic [15:0]           DataIn,
    output logic [2:0]            vAddr,
    output logic                  vRD_p,
    output logic                  vWR_p,
    output logic [16*LANES-1:0]   vInP,
    input  logic [16*LANES-1:0]   vOutP
);

    localparam int         VW   = 16 * LANES;
    localparam int         LW   = $clog2(LANES);
    localparam logic [4:0] LAST = 5'(LANES - 1);

    typedef enum logic [2:0] {
        IDLE, LD_RD, LD_WAIT, LD_VWR, ST_VRD, ST_WR, FIN
    } state_t;

    state_t          state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [VW-1:0]   buf_q, buf_d;
    logic [2:0]      vreg_q, vreg_d;
    logic [15:0]     base_q, base_d;

    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [15:0]     addr_q, addr_d;
    logic            rd_q, rd_d;
    logic            wr_q, wr_d;
    logic [15:0]     dout_q, dout_d;
    logic [2:0]      vaddr_q, vaddr_d;
    logic            vrd_q, vrd_d;
    logic            vwr_q, vwr_d;
    logic [VW-1:0]   vinp_q, vinp_d;

    logic [4:0]      nxt_cnt;
    logic [LW-1:0]   cap_lane;
    logic [LW-1:0]   nxt_lane;

    // Read data lags the address by one cycle, so LD_RD stores the lane
    // issued in the previous cycle.
    assign nxt_cnt  = cnt_q + 5'd1;
    assign cap_lane = LW'(cnt_q - 5'd1);
    assign nxt_lane = LW'(nxt_cnt);

    // Next-state and next-output logic; outputs are registered so each
    // branch sets what the bus should show in the following cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        vreg_d  = vreg_q;
        base_d  = base_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        addr_d  = 16'd0;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        dout_d  = 16'd0;
        vaddr_d = 3'd0;
        vrd_d   = 1'b0;
        vwr_d   = 1'b0;
        vinp_d  = '0;

        case (state_q)
            IDLE, FIN: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                if (start) begin
                    vreg_d = vreg;
                    base_d = base;
                    cnt_d  = 5'd0;
                    busy_d = 1'b1;
                    if (!op) begin
                        state_d = LD_RD;
                        rd_d    = 1'b1;
                        addr_d  = base;
                    end else begin
                        state_d = ST_VRD;
                        vrd_d   = 1'b1;
                        vaddr_d = vreg;
                    end
                end
            end
            LD_RD: begin
                if (cnt_q != 5'd0)
                    buf_d[{cap_lane, 4'b0000} +: 16] = DataIn;
                if (cnt_q == LAST) begin
                    state_d = LD_WAIT;
                end else begin
                    cnt_d  = nxt_cnt;
                    rd_d   = 1'b1;
                    addr_d = base_q + 16'(nxt_cnt);
                end
            end
            LD_WAIT: begin
                buf_d[VW-1 -: 16] = DataIn;
                state_d = LD_VWR;
                vwr_d   = 1'b1;
                vaddr_d = vreg_q;
                vinp_d  = buf_d;
            end
            LD_VWR: begin
                state_d = FIN;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end
            ST_VRD: begin
                buf_d   = vOutP;
                cnt_d   = 5'd0;
                state_d = ST_WR;
                wr_d    = 1'b1;
                addr_d  = base_q;
                dout_d  = vOutP[15:0];
            end
            ST_WR: begin
                if (cnt_q == LAST) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d  = nxt_cnt;
                    wr_d   = 1'b1;
                    addr_d = base_q + 16'(nxt_cnt);
                    dout_d = buf_q[{nxt_lane, 4'b0000} +: 16];
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers; reset drops any partial buffer.
    always_ff @(posedge Clk1) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            buf_q   <= '0;
            vreg_q  <= 3'd0;
            base_q  <= 16'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= 16'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            dout_q  <= 16'd0;
            vaddr_q <= 3'd0;
            vrd_q   <= 1'b0;
            vwr_q   <= 1'b0;
            vinp_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            vreg_q  <= vreg_d;
            base_q  <= base_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            dout_q  <= dout_d;
            vaddr_q <= vaddr_d;
            vrd_q   <= vrd_d;
            vwr_q   <= vwr_d;
            vinp_q  <= vinp_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign Addr    = addr_q;
    assign RD      = rd_q;
    assign WR      = wr_q;
    assign DataOut = dout_q;
    assign vAddr   = vaddr_q;
    assign vRD_p   = vrd_q;
    assign vWR_p   = vwr_q;
    assign vInP    = vinp_q;

endmodule
